hazard_ctrl: RTL and testbench

Pipeline hazard controller that produces the stall/flush controls consumed by the IF/ID pipeline register (`if_id_write`, `if_id_flush`), plus the PC enable, the ID/EX bubble and the back-end freeze.

- Sits beside the ID stage.
- Detects load-use hazards, control-flow redirects, instruction-memory misses and multi-cycle data-memory waits.
- Sequences the pipeline through them with a small FSM.
- Keeps a saturating stall counter and a sticky data-memory timeout flag.

---
 rtl/cpu_pipe_pkg.sv | 14 +
 rtl/load_use_detect.sv | 24 ++
 rtl/hazard_ctrl.sv | 122 ++++++++++++
 tb/tb_hazard_ctrl.sv | 263 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared pipeline definitions: register-field width, $zero index and hazard FSM states.
package cpu_pipe_pkg;

  localparam int unsigned REG_W = 5;

  localparam logic [REG_W-1:0] REG_ZERO = 5'd0;

  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_MEM_WAIT = 2'd2
  } hz_state_e;

endpackage : cpu_pipe_pkg

// File: rtl/load_use_detect.sv
// Load-use comparator: the EX load writes a register the ID instruction reads.
// Writes to $zero never create a dependency.
module load_use_detect
  import cpu_pipe_pkg::*;
(
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  output logic             load_use_c
);

  logic rs_match;
  logic rt_match;

  // Source-operand matches against the load destination
  always_comb begin
    rs_match   = (ex_rt == id_rs);
    rt_match   = id_uses_rt && (ex_rt == id_rt);
    load_use_c = ex_mem_read && (ex_rt != REG_ZERO) && (rs_match || rt_match);
  end

endmodule : load_use_detect

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: IF/ID stall/flush, PC enable, ID/EX bubble and
// back-end freeze, plus a saturating stall counter and sticky dmem timeout flag.
// Control outputs are combinational from state and inputs (same-cycle response).
module hazard_ctrl
  import cpu_pipe_pkg::*;
#(
  parameter int unsigned MAX_WAIT = 15,
  parameter int unsigned CNT_W    = 16
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [REG_W-1:0] id_rs,
  input  logic [REG_W-1:0] id_rt,
  input  logic             id_uses_rt,
  input  logic             ex_mem_read,
  input  logic [REG_W-1:0] ex_rt,
  input  logic             redirect,
  input  logic             imem_ready,
  input  logic             dmem_busy,
  output logic             pc_write,
  output logic             if_id_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             back_write,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             mem_timeout
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT + 1);

  hz_state_e         state_q;
  hz_state_e         state_d;
  logic              load_use;
  logic              wait_busy;
  logic [WAIT_W-1:0] wait_cnt_q;

  load_use_detect u_load_use_detect (
    .ex_mem_read (ex_mem_read),
    .ex_rt       (ex_rt),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_uses_rt  (id_uses_rt),
    .load_use_c  (load_use)
  );

  // FSM state register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and control decode; first matching condition wins.
  // LU_STALL ignores load_use so each load inserts exactly one bubble;
  // MEM_WAIT with dmem_busy low falls through and decodes exactly like RUN.
  always_comb begin
    state_d     = ST_RUN;
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_id_flush = 1'b0;
    id_ex_flush = 1'b0;
    back_write  = 1'b1;
    if (reset) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      back_write  = 1'b0;
      if_id_flush = 1'b1;
      id_ex_flush = 1'b1;
    end else if (dmem_busy) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      back_write  = 1'b0;
      state_d     = ST_MEM_WAIT;
    end else if (load_use && (state_q != ST_LU_STALL)) begin
      pc_write    = 1'b0;
      if_id_write = 1'b0;
      id_ex_flush = 1'b1;
      state_d     = ST_LU_STALL;
    end else if (redirect) begin
      if_id_flush = 1'b1;
    end else if (!imem_ready) begin
      pc_write    = 1'b0;
      if_id_flush = 1'b1;
    end
  end

  assign wait_busy = (state_q == ST_MEM_WAIT) && dmem_busy;

  // Data-memory wait counter: counts busy cycles in MEM_WAIT, clears otherwise
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wait_cnt_q <= '0;
    end else if (wait_busy) begin
      if (wait_cnt_q != WAIT_W'(MAX_WAIT)) begin
        wait_cnt_q <= wait_cnt_q + WAIT_W'(1);
      end
    end else begin
      wait_cnt_q <= '0;
    end
  end

  // Sticky timeout: sets on the edge where the wait count reaches MAX_WAIT while still busy
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_timeout <= 1'b0;
    end else if (wait_busy && (wait_cnt_q >= WAIT_W'(MAX_WAIT - 1))) begin
      mem_timeout <= 1'b1;
    end
  end

  // Saturating count of cycles with the PC held
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stall_cycles <= '0;
    end else if (!pc_write && (stall_cycles != {CNT_W{1'b1}})) begin
      stall_cycles <= stall_cycles + CNT_W'(1);
    end
  end

endmodule : hazard_ctrl

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl. Inputs change on the falling edge; outputs are
// sampled 1 ns later. ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write}.
module tb_hazard_ctrl;

  localparam logic [4:0] C_RESET = 5'b00110;
  localparam logic [4:0] C_NORM  = 5'b11001;
  localparam logic [4:0] C_LU    = 5'b00011;
  localparam logic [4:0] C_REDIR = 5'b11101;
  localparam logic [4:0] C_FREEZ = 5'b00000;
  localparam logic [4:0] C_IMISS = 5'b01101;

  logic        clock;
  logic        reset;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic        id_uses_rt;
  logic        ex_mem_read;
  logic [4:0]  ex_rt;
  logic        redirect;
  logic        imem_ready;
  logic        dmem_busy;

  logic        pc_write, if_id_write, if_id_flush, id_ex_flush, back_write;
  logic [15:0] stall_cycles;
  logic        mem_timeout;

  logic        s_pc_write, s_if_id_write, s_if_id_flush, s_id_ex_flush, s_back_write;
  logic [3:0]  s_stall_cycles;
  logic        s_mem_timeout;

  logic [4:0]  ctrl;
  assign ctrl = {pc_write, if_id_write, if_id_flush, id_ex_flush, back_write};

  int unsigned n_checks;
  int unsigned n_fail;

  hazard_ctrl #(.MAX_WAIT(15), .CNT_W(16)) u_dut (
    .clock        (clock),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .redirect     (redirect),
    .imem_ready   (imem_ready),
    .dmem_busy    (dmem_busy),
    .pc_write     (pc_write),
    .if_id_write  (if_id_write),
    .if_id_flush  (if_id_flush),
    .id_ex_flush  (id_ex_flush),
    .back_write   (back_write),
    .stall_cycles (stall_cycles),
    .mem_timeout  (mem_timeout)
  );

  hazard_ctrl #(.MAX_WAIT(15), .CNT_W(4)) u_sat (
    .clock        (clock),
    .reset        (reset),
    .id_rs        (id_rs),
    .id_rt        (id_rt),
    .id_uses_rt   (id_uses_rt),
    .ex_mem_read  (ex_mem_read),
    .ex_rt        (ex_rt),
    .redirect     (redirect),
    .imem_ready   (imem_ready),
    .dmem_busy    (dmem_busy),
    .pc_write     (s_pc_write),
    .if_id_write  (s_if_id_write),
    .if_id_flush  (s_if_id_flush),
    .id_ex_flush  (s_id_ex_flush),
    .back_write   (s_back_write),
    .stall_cycles (s_stall_cycles),
    .mem_timeout  (s_mem_timeout)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    id_rs       = 5'd0;
    id_rt       = 5'd0;
    id_uses_rt  = 1'b0;
    ex_mem_read = 1'b0;
    ex_rt       = 5'd0;
    redirect    = 1'b0;
    imem_ready  = 1'b1;
    dmem_busy   = 1'b0;
  endtask

  // Advance to the next falling edge (inputs may then be changed)
  task automatic next_cyc();
    @(negedge clock);
  endtask

  task automatic apply_reset();
    next_cyc();
    reset = 1'b1;
    set_idle();
    #1;
    check_eq("rst_ctrl", 32'(ctrl), 32'(C_RESET));
    check_eq("rst_stall", 32'(stall_cycles), 32'd0);
    next_cyc();
    reset = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    set_idle();

    // Reset state
    #1;
    check_eq("reset_ctrl", 32'(ctrl), 32'(C_RESET));
    check_eq("reset_stall_cycles", 32'(stall_cycles), 32'd0);
    check_eq("reset_timeout", 32'(mem_timeout), 32'd0);
    next_cyc();
    reset = 1'b0;
    #1;
    check_eq("run_idle", 32'(ctrl), 32'(C_NORM));

    // Load-use: one bubble, then released even with inputs held
    next_cyc();
    ex_mem_read = 1'b1; ex_rt = 5'd8; id_rs = 5'd8;
    #1;
    check_eq("lu_stall", 32'(ctrl), 32'(C_LU));
    next_cyc();
    #1;
    check_eq("lu_release_held", 32'(ctrl), 32'(C_NORM));
    check_eq("lu_stall_cycles", 32'(stall_cycles), 32'd1);

    // $zero load and unread rt: no stall
    next_cyc();
    set_idle();
    ex_mem_read = 1'b1;
    #1;
    check_eq("zero_load", 32'(ctrl), 32'(C_NORM));
    next_cyc();
    ex_rt = 5'd8; id_rt = 5'd8; id_rs = 5'd3; id_uses_rt = 1'b0;
    #1;
    check_eq("rt_unused", 32'(ctrl), 32'(C_NORM));
    next_cyc();
    id_uses_rt = 1'b1;
    #1;
    check_eq("rt_used_stall", 32'(ctrl), 32'(C_LU));
    next_cyc();
    set_idle();
    #1;
    check_eq("after_rt_stall", 32'(ctrl), 32'(C_NORM));

    // Redirect alone, then redirect together with load-use
    next_cyc();
    redirect = 1'b1;
    #1;
    check_eq("redirect_run", 32'(ctrl), 32'(C_REDIR));
    next_cyc();
    ex_mem_read = 1'b1; ex_rt = 5'd9; id_rs = 5'd9;
    #1;
    check_eq("lu_beats_redirect", 32'(ctrl), 32'(C_LU));
    next_cyc();
    #1;
    check_eq("redirect_in_lu", 32'(ctrl), 32'(C_REDIR));
    next_cyc();
    set_idle();
    #1;
    check_eq("after_redirect", 32'(ctrl), 32'(C_NORM));
    check_eq("stall_cycles_3", 32'(stall_cycles), 32'd3);

    // Data-memory wait of 3 cycles, with redirect pending (freeze wins)
    apply_reset();
    for (int i = 0; i < 3; i++) begin
      if (i > 0) next_cyc();
      dmem_busy = 1'b1; redirect = 1'b1;
      #1;
      check_eq($sformatf("dmem_freeze_%0d", i), 32'(ctrl), 32'(C_FREEZ));
    end
    next_cyc();
    dmem_busy = 1'b0;
    #1;
    check_eq("dmem_resume_redirect", 32'(ctrl), 32'(C_REDIR));
    check_eq("dmem_stall_cycles", 32'(stall_cycles), 32'd3);
    check_eq("dmem_no_timeout", 32'(mem_timeout), 32'd0);
    next_cyc();
    set_idle();
    #1;
    check_eq("dmem_after", 32'(ctrl), 32'(C_NORM));

    // Long wait: 16 busy cycles trips the sticky timeout
    for (int i = 0; i < 16; i++) begin
      next_cyc();
      dmem_busy = 1'b1;
    end
    #1;
    check_eq("long_wait_freeze", 32'(ctrl), 32'(C_FREEZ));
    next_cyc();
    dmem_busy = 1'b0;
    #1;
    check_eq("timeout_set", 32'(mem_timeout), 32'd1);
    check_eq("long_wait_resume", 32'(ctrl), 32'(C_NORM));
    next_cyc();
    next_cyc();
    #1;
    check_eq("timeout_sticky", 32'(mem_timeout), 32'd1);

    // Reset in the middle of a wait discards everything
    next_cyc();
    dmem_busy = 1'b1;
    next_cyc();
    next_cyc();
    reset = 1'b1;
    #1;
    check_eq("midwait_rst_ctrl", 32'(ctrl), 32'(C_RESET));
    check_eq("midwait_rst_stall", 32'(stall_cycles), 32'd0);
    check_eq("midwait_rst_timeout", 32'(mem_timeout), 32'd0);
    next_cyc();
    reset = 1'b0;
    dmem_busy = 1'b0;
    #1;
    check_eq("post_rst_run", 32'(ctrl), 32'(C_NORM));
    next_cyc();
    #1;
    check_eq("post_rst_stall", 32'(stall_cycles), 32'd0);

    // Instruction-memory miss for 2 cycles
    imem_ready = 1'b0;
    #1;
    check_eq("imiss_0", 32'(ctrl), 32'(C_IMISS));
    next_cyc();
    #1;
    check_eq("imiss_1", 32'(ctrl), 32'(C_IMISS));
    next_cyc();
    imem_ready = 1'b1;
    #1;
    check_eq("imiss_resume", 32'(ctrl), 32'(C_NORM));
    check_eq("imiss_stall_cycles", 32'(stall_cycles), 32'd2);

    // Counter saturation: 20 stalled cycles on the 4-bit instance
    apply_reset();
    for (int i = 0; i < 20; i++) begin
      if (i > 0) next_cyc();
      dmem_busy = 1'b1;
    end
    next_cyc();
    dmem_busy = 1'b0;
    #1;
    check_eq("sat_cnt4", 32'(s_stall_cycles), 32'd15);
    check_eq("wide_cnt16", 32'(stall_cycles), 32'd20);

    next_cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_hazard_ctrl
